rv_initiator: RTL and testbench

- Upstream end of the team's ready-valid handshake: issues one request to a latency-insensitive compute module and collects its single response.
- Accepts a command from the local side, drives the request channel and waits for the response. Presents the result on a held done channel.
- Sits between a test driver or control FSM and any module built on the team's IDLE/COMPUTE/VALID controller.
- Exactly one transaction is in flight at a time.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/rv_initiator_fsm.sv | 62 ++++++
 rtl/rv_initiator.sv | 107 ++++++++++
 tb/tb_rv_initiator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared ready-valid handshake types: initiator state encoding, the IDLE/COMPUTE/VALID
// controller encoding used by compute modules, and the transaction counter width.
package rv_pkg;

    localparam int unsigned TXN_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        INIT_IDLE = 2'b00,
        INIT_SEND = 2'b01,
        INIT_WAIT = 2'b10,
        INIT_DONE = 2'b11
    } init_state_e;

    typedef enum logic [1:0] {
        CTL_IDLE    = 2'b00,
        CTL_COMPUTE = 2'b01,
        CTL_VALID   = 2'b10
    } ctl_state_e;

    // A channel transfers data in any cycle where both sides agree at the rising edge.
    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/rv_initiator_fsm.sv
// Next-state and control decode for the ready-valid initiator; the state register
// itself lives in the top level.
module rv_initiator_fsm
    import rv_pkg::*;
(
    input  init_state_e state,
    input  logic        cmd_valid,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic        done_ready,
    input  logic        timeout_hit,
    output init_state_e next_state,
    output logic        cmd_ready_c,
    output logic        req_valid_c,
    output logic        resp_ready_c,
    output logic        done_valid_c,
    output logic        busy_c,
    output logic        cmd_fire_c,
    output logic        req_fire_c,
    output logic        resp_fire_c,
    output logic        done_fire_c
);

    // Control outputs depend on state only; fire strobes qualify the input with that decode.
    always_comb begin
        next_state   = state;
        cmd_ready_c  = 1'b0;
        req_valid_c  = 1'b0;
        resp_ready_c = 1'b0;
        done_valid_c = 1'b0;
        cmd_fire_c   = 1'b0;
        req_fire_c   = 1'b0;
        resp_fire_c  = 1'b0;
        done_fire_c  = 1'b0;
        busy_c       = (state != INIT_IDLE);

        case (state)
            INIT_IDLE: begin
                cmd_ready_c = 1'b1;
                cmd_fire_c  = fire(cmd_valid, 1'b1);
                if (cmd_valid) next_state = INIT_SEND;
            end
            INIT_SEND: begin
                req_valid_c = 1'b1;
                req_fire_c  = fire(1'b1, req_ready);
                if (req_ready) next_state = INIT_WAIT;
            end
            INIT_WAIT: begin
                resp_ready_c = 1'b1;
                resp_fire_c  = fire(resp_valid, 1'b1);
                if (resp_valid || timeout_hit) next_state = INIT_DONE;
            end
            INIT_DONE: begin
                done_valid_c = 1'b1;
                done_fire_c  = fire(1'b1, done_ready);
                if (done_ready) next_state = INIT_IDLE;
            end
            default: next_state = INIT_IDLE;
        endcase
    end

endmodule

// File: rtl/rv_initiator.sv
// Ready-valid initiator: one command -> one request -> one response -> held done result.
// Optional WAIT timeout enabled by defining RV_INITIATOR_TIMEOUT_EN.
module rv_initiator
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RESULT_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [DATA_WIDTH-1:0]      req_data,
    input  logic                       resp_valid,
    output logic                       resp_ready,
    input  logic [RESULT_WIDTH-1:0]    resp_data,
    output logic                       done_valid,
    input  logic                       done_ready,
    output logic [RESULT_WIDTH-1:0]    done_data,
    output logic                       timeout,
    output logic [TXN_COUNT_WIDTH-1:0] txn_count,
    output logic                       busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rv_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    init_state_e state;
    init_state_e next_state;
    logic        cmd_fire;
    logic        req_fire;
    logic        resp_fire;
    logic        done_fire;
    logic        timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_IDLE;
        else       state <= next_state;
    end

    rv_initiator_fsm u_fsm (
        .state        (state),
        .cmd_valid    (cmd_valid),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .done_ready   (done_ready),
        .timeout_hit  (timeout_hit),
        .next_state   (next_state),
        .cmd_ready_c  (cmd_ready),
        .req_valid_c  (req_valid),
        .resp_ready_c (resp_ready),
        .done_valid_c (done_valid),
        .busy_c       (busy),
        .cmd_fire_c   (cmd_fire),
        .req_fire_c   (req_fire),
        .resp_fire_c  (resp_fire),
        .done_fire_c  (done_fire)
    );

    // Request payload is captured once and held until the request handshake completes.
    always_ff @(posedge clk) begin
        if (reset)         req_data <= '0;
        else if (cmd_fire) req_data <= cmd_data;
    end

    // A real response takes priority over a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_data <= '0;
            timeout   <= 1'b0;
        end else if (resp_fire) begin
            done_data <= resp_data;
            timeout   <= 1'b0;
        end else if (timeout_hit) begin
            done_data <= '0;
            timeout   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          txn_count <= '0;
        else if (done_fire) txn_count <= txn_count + TXN_COUNT_WIDTH'(1);
    end

`ifdef RV_INITIATOR_TIMEOUT_EN
    localparam int unsigned TO_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles; held at zero in every other state so WAIT entry starts clean.
    always_ff @(posedge clk) begin
        if (reset || (state != INIT_WAIT)) wait_cnt <= '0;
        else if (wait_cnt != TO_LIMIT)     wait_cnt <= wait_cnt + TO_CNT_W'(1);
    end

    assign timeout_hit = (state == INIT_WAIT) && (wait_cnt == TO_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rv_initiator.sv
// Self-checking bench for rv_initiator: directed scenarios plus randomized transactions
// checked against a transaction-level model of the handshake sequence.
module tb_rv_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        done_valid;
    logic        done_ready;
    logic [31:0] done_data;
    logic        timeout;
    logic [15:0] txn_count;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    int req_hs = 0;

    rv_initiator #(.DATA_WIDTH(32), .RESULT_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_data  (done_data),
        .timeout    (timeout),
        .txn_count  (txn_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && req_valid === 1'b1 && req_ready === 1'b1) req_hs++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (cmd_ready !== 1'b1 || req_valid !== 1'b0 || resp_ready !== 1'b0 ||
            done_valid !== 1'b0 || busy !== 1'b0 || txn_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL %s: cmd_ready=%b req_valid=%b resp_ready=%b done_valid=%b busy=%b txn_count=%0d, want 1 0 0 0 0 %0d",
                     tag, cmd_ready, req_valid, resp_ready, done_valid, busy, txn_count, exp_count);
        end
    endtask

    // One full transaction with the given stall lengths on each channel.
    task automatic run_txn(input logic [31:0] d, input logic [31:0] r, input int req_dly,
                           input int resp_dly, input int done_dly, input string tag);
        int hs0;
        hs0 = req_hs;
        check_idle({tag, "_start"});
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        for (int i = 0; i <= req_dly; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_data !== d || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_send[%0d]: req_valid=%b req_data=%h cmd_ready=%b busy=%b, want 1 %h 0 1",
                         tag, i, req_valid, req_data, cmd_ready, busy, d);
            end
            if (i == req_dly) req_ready = 1'b1;
            tick();
        end
        req_ready = 1'b0;
        checks++;
        if (req_hs - hs0 != 1) begin
            errors++;
            $display("FAIL %s_req_hs: got %0d request handshakes, want 1", tag, req_hs - hs0);
        end
        for (int i = 0; i <= resp_dly; i++) begin
            checks++;
            if (resp_ready !== 1'b1 || done_valid !== 1'b0 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait[%0d]: resp_ready=%b done_valid=%b req_valid=%b, want 1 0 0",
                         tag, i, resp_ready, done_valid, req_valid);
            end
            if (i == resp_dly) begin
                resp_valid = 1'b1;
                resp_data  = r;
            end
            tick();
        end
        resp_valid = 1'b0;
        resp_data  = $urandom;
        for (int i = 0; i <= done_dly; i++) begin
            checks++;
            if (done_valid !== 1'b1 || done_data !== r || timeout !== 1'b0 ||
                cmd_ready !== 1'b0 || txn_count !== 16'(exp_count)) begin
                errors++;
                $display("FAIL %s_done[%0d]: done_valid=%b done_data=%h timeout=%b cmd_ready=%b txn_count=%0d, want 1 %h 0 0 %0d",
                         tag, i, done_valid, done_data, timeout, cmd_ready, txn_count, r, exp_count);
            end
            if (i == done_dly) done_ready = 1'b1;
            tick();
        end
        done_ready = 1'b0;
        exp_count  = (exp_count + 1) % 65536;
        check_idle({tag, "_end"});
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        exp_count = 0;
        checks++;
        if (req_data !== 32'h0 || done_data !== 32'h0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: req_data=%h done_data=%h timeout=%b, want 0 0 0",
                     req_data, done_data, timeout);
        end
        check_idle("reset_ctrl");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        run_txn(32'h0000_0005, 32'h19, 0, 0, 0, "single");
        checks++;
        if (txn_count !== 16'd1) begin
            errors++;
            $display("FAIL single_count: txn_count=%0d, want 1", txn_count);
        end
    endtask

    task automatic test_backpressure;
        run_txn(32'hA5A5_0001, 32'h1234_5678, 7, 1, 0, "backpressure");
    endtask

    task automatic test_stalled_done;
        run_txn(32'h0BAD_F00D, 32'hCAFE_0002, 0, 2, 5, "stalled_done");
    endtask

    task automatic test_stray_resp;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (done_valid !== 1'b0 || resp_ready !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray_idle[%0d]: done_valid=%b resp_ready=%b cmd_ready=%b, want 0 0 1",
                         i, done_valid, resp_ready, cmd_ready);
            end
        end
        resp_valid = 1'b0;
        run_txn(32'h0000_1234, 32'h77, 1, 0, 1, "stray_next");
    endtask

    task automatic test_reset_in_wait;
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_00AA;
        tick();
        cmd_valid = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checks++;
        if (resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_enter: resp_ready=%b, want 1", resp_ready);
        end
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_count = 0;
        check_idle("rst_wait_idle");
        resp_valid = 1'b1;
        resp_data  = 32'hBEEF;
        tick();
        tick();
        resp_valid = 1'b0;
        checks++;
        if (done_valid !== 1'b0 || resp_ready !== 1'b0 || done_data !== 32'h0 || req_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_late: done_valid=%b resp_ready=%b done_data=%h req_data=%h, want 0 0 0 0",
                     done_valid, resp_ready, done_data, req_data);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 16; n++) begin
            run_txn($urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), "random");
        end
    endtask

`ifdef RV_INITIATOR_TIMEOUT_EN
    task automatic test_timeout;
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_0042;
        tick();
        cmd_valid = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (done_valid !== 1'b0 || resp_ready !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: done_valid=%b resp_ready=%b, want 0 1",
                         i, done_valid, resp_ready);
            end
            tick();
        end
        checks++;
        if (done_valid !== 1'b1 || timeout !== 1'b1 || done_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_done: done_valid=%b timeout=%b done_data=%h, want 1 1 0",
                     done_valid, timeout, done_data);
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        exp_count  = (exp_count + 1) % 65536;
        check_idle("timeout_end");
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_count = 0;
        check_idle("timeout_reset");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        done_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_stalled_done();
        test_stray_resp();
        test_reset_in_wait();
        test_random();
`ifdef RV_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
